// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types, constants and helpers for the div_arb scheduler.
//   state_t      FSM state encoding (IDLE, CALC, FIX, RESP)
//   dbg_t        debug view of the scheduler FSM and the divide engine
//   cnt_width()  iteration-counter width for an N-iteration loop
//   sat_pos()    most positive two's-complement value of a given width
//   sat_neg()    most negative two's-complement value of a given width
package div_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        state_t state;
        logic   busy;
        logic   done;
    } dbg_t;

    // Counter must be able to hold the value N itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// div_iter_core: unsigned restoring divider, one quotient bit per clock.
//   clk, rst  clock, asynchronous active-high reset
//   start     load operands and begin N iterations (ignored bits of state are overwritten)
//   dividend  N-bit unsigned dividend
//   divisor   (DW+1)-bit unsigned divisor magnitude
//   busy      high while iterations remain
//   done      high from the last iteration until the next start
//   quot      N-bit quotient register
module div_iter_core
    import div_arb_pkg::*;
#(
    parameter int N  = 24,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  dividend,
    input  logic [DW:0]   divisor,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  quot
);

    localparam int CNT_W = cnt_width(N);
    localparam int NW    = N + 1;

    logic [N-1:0]     rem_q, rem_d;
    logic [N-1:0]     quot_q, quot_d;
    logic [DW:0]      div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N:0]       shifted;
    logic [N:0]       diff;

    always_comb begin
        // Remainder stays below the divisor, so the extra top bit only
        // serves as the borrow of the trial subtraction.
        shifted = {rem_q, quot_q[N-1]};
        diff    = shifted - NW'(div_q);

        rem_d  = rem_q;
        quot_d = quot_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;

        if (start) begin
            rem_d  = '0;
            quot_d = dividend;
            div_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (!diff[N]) begin
                rem_d  = diff[N-1:0];
                quot_d = {quot_q[N-2:0], 1'b1};
            end else begin
                rem_d  = shifted[N-1:0];
                quot_d = {quot_q[N-2:0], 1'b0};
            end
            if (cnt_q == CNT_W'(N - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quot = quot_q;

endmodule

// File: rtl/div_arb.sv
// div_arb: round-robin scheduler sharing one iterative signed fixed-point
// divider among NUM_REQ requesters. Result = (a * 2^BIN_POS) / b, truncated
// toward zero.
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester handshake; req_ready is a one-hot grant
//   req_a, req_b      packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid/ready   response handshake
//   rsp_id            requester owning the response
//   rsp_quot          quotient
//   rsp_dbz           divisor was zero
//   dbg               FSM state plus engine busy/done
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid may drop without a transfer, and ready depends on
// valid only through the arbiter.
// Build option DIV_ARB_SAT_EN: saturate out-of-range and divide-by-zero
// results instead of wrapping.
module div_arb
    import div_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BIN_POS    = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_quot,
    output logic                          rsp_dbz,
    output dbg_t                          dbg
);

    localparam int N     = DATA_WIDTH + BIN_POS;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(N);
    localparam int AW    = DATA_WIDTH + 1;
    localparam int NW    = N + 1;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  a_neg_q, a_neg_d;
    logic                  neg_q, neg_d;
    logic                  dbz_q, dbz_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_quot_q, rsp_quot_d;
    logic                  rsp_dbz_q, rsp_dbz_d;

    logic                  found;
    logic [ID_W-1:0]       win_id;
    logic [DATA_WIDTH-1:0] a_sel, b_sel;
    logic [AW-1:0]         a_ext, b_ext, a_mag, b_mag;
    logic [N-1:0]          dividend;
    logic                  core_start;
    logic                  core_busy, core_done;
    logic [N-1:0]          core_quot;
    logic [N:0]            signed_res;
    logic [DATA_WIDTH-1:0] fix_quot;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[wrap_add(ptr_q, i)]) begin
                found  = 1'b1;
                win_id = wrap_add(ptr_q, i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && found) req_ready = NUM_REQ'(1) << win_id;
    end

    // Operand magnitudes are one bit wider so -2^(W-1) stays representable.
    always_comb begin
        a_sel    = req_a[win_id*DATA_WIDTH +: DATA_WIDTH];
        b_sel    = req_b[win_id*DATA_WIDTH +: DATA_WIDTH];
        a_ext    = {a_sel[DATA_WIDTH-1], a_sel};
        b_ext    = {b_sel[DATA_WIDTH-1], b_sel};
        a_mag    = a_ext[AW-1] ? (~a_ext + AW'(1)) : a_ext;
        b_mag    = b_ext[AW-1] ? (~b_ext + AW'(1)) : b_ext;
        dividend = N'(a_mag) << BIN_POS;
    end

    div_iter_core #(
        .N  (N),
        .DW (DATA_WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .dividend (dividend),
        .divisor  (b_mag),
        .busy     (core_busy),
        .done     (core_done),
        .quot     (core_quot)
    );

    // Final quotient from the unsigned engine result and the saved signs.
    always_comb begin
        signed_res = neg_q ? (~NW'(core_quot) + NW'(1)) : NW'(core_quot);
`ifdef DIV_ARB_SAT_EN
        if (dbz_q) begin
            fix_quot = a_neg_q ? DATA_WIDTH'(sat_neg(DATA_WIDTH)) : DATA_WIDTH'(sat_pos(DATA_WIDTH));
        end else if (!neg_q && core_quot > N'(sat_pos(DATA_WIDTH))) begin
            fix_quot = DATA_WIDTH'(sat_pos(DATA_WIDTH));
        end else if (neg_q && core_quot > N'(sat_neg(DATA_WIDTH))) begin
            fix_quot = DATA_WIDTH'(sat_neg(DATA_WIDTH));
        end else begin
            fix_quot = DATA_WIDTH'(signed_res);
        end
`else
        if (dbz_q) fix_quot = '1;
        else       fix_quot = DATA_WIDTH'(signed_res);
`endif
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        a_neg_d     = a_neg_q;
        neg_d       = neg_q;
        dbz_d       = dbz_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_quot_d  = rsp_quot_q;
        rsp_dbz_d   = rsp_dbz_q;
        core_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_CALC;
                    ptr_d      = wrap_add(win_id, 1);
                    id_d       = win_id;
                    a_neg_d    = a_sel[DATA_WIDTH-1];
                    neg_d      = a_sel[DATA_WIDTH-1] ^ b_sel[DATA_WIDTH-1];
                    dbz_d      = (b_sel == '0);
                    cnt_d      = '0;
                    // A zero divisor skips the engine; CALC still runs its
                    // full length so latency does not depend on operands.
                    core_start = (b_sel != '0);
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_quot_d  = fix_quot;
                rsp_dbz_d   = dbz_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            a_neg_q     <= 1'b0;
            neg_q       <= 1'b0;
            dbz_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quot_q  <= '0;
            rsp_dbz_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            a_neg_q     <= a_neg_d;
            neg_q       <= neg_d;
            dbz_q       <= dbz_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quot_q  <= rsp_quot_d;
            rsp_dbz_q   <= rsp_dbz_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_quot   = rsp_quot_q;
    assign rsp_dbz    = rsp_dbz_q;
    assign dbg.state  = state_q;
    assign dbg.busy   = core_busy;
    assign dbg.done   = core_done;

endmodule
